merging_store_buffer: RTL
=========================

MERGING_STORE_BUFFER -- requirements
Module: merging_store_buffer

Interface
REQ-001 SHALL have parameters: DEPTH, default 8, entry count (power of two, >=2); ADDR_W, default 32, address width; DATA_W, default 32, data width (multiple of 8, byte lanes NB=DATA_W/8).
REQ-002 SHALL have ports (name  direction  width  meaning): clk_i  in  1  sole clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-003 flush_i  in  1  discard all uncommitted entries.
REQ-004 push_valid_i  in  1  store offered; push_ready_o  out  1  store accepted when both high.
REQ-005 push_addr_i  in  ADDR_W; push_data_i  in  DATA_W; push_strb_i  in  NB  byte enables of offered store.
REQ-006 commit_i  in  1  ROB retires oldest uncommitted store.
REQ-007 mem_req_o  out  1; mem_addr_o  out  ADDR_W; mem_data_o  out  DATA_W; mem_strb_o  out  NB; mem_done_i  in  1  memory write complete.
REQ-008 fwd_addr_i  in  ADDR_W  load address; fwd_data_o  out  DATA_W; fwd_strb_o  out  NB  bytes supplied by buffer; fwd_hit_o  out  1  any byte supplied.
REQ-009 full_o  out  1; empty_o  out  1; count_o  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-010 Circular FIFO with head (drain), commit and tail (push) pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH; entry state FREE/SPEC/COMMITTED/INFLIGHT.
REQ-011 push_ready_o = !full_o & !flush_i; accepted push writes addr/data/strb at tail, state SPEC, tail+1, visible next cycle.
REQ-012 commit_i marks entry at commit pointer COMMITTED, pointer+1; commit_i with no SPEC entry SHALL be ignored and flagged by assertion.
REQ-013 flush_i: tail <= commit pointer (after same-cycle commit applied), SPEC entries -> FREE; COMMITTED/INFLIGHT kept; same-cycle push rejected.
REQ-014 Drain FSM IDLE/REQ: IDLE->REQ when head entry COMMITTED (head -> INFLIGHT); REQ holds mem_req_o=1 with mem_addr_o/data/strb stable from head; mem_done_i in REQ -> head FREE, head+1, IDLE. One outstanding request; mem_done_i outside REQ ignored.
REQ-015 Latency: commit_i at cycle N -> mem_req_o at N+2 earliest; back-to-back drains separated by one IDLE cycle.
REQ-016 Forwarding combinational: per byte lane b, select youngest non-FREE entry with addr[ADDR_W-1:2] match and strb[b]=1; fwd_strb_o[b]=1, fwd_data_o lane b from it; unmatched lanes output 0; fwd_hit_o = |fwd_strb_o.
REQ-017 Entries freed by mem_done_i or flush SHALL not forward from the next cycle.
REQ-018 count_o updates on push(+1), drain-complete(-1), flush(-SPEC count); simultaneous push and drain-complete leaves count unchanged; full_o = count_o==DEPTH, empty_o = count_o==0, both registered-consistent with count_o.
REQ-019 Push when full rejected even if same-cycle drain frees an entry.

Reset
REQ-020 rst_i asserted: all entries FREE, pointers 0, FSM IDLE, count_o=0, empty_o=1, full_o=0, mem_req_o=0, fwd_hit_o=0, push_ready_o=1 after release.
REQ-021 Reset mid-REQ SHALL drop mem_req_o immediately; pending write abandoned; data arrays need no reset.

Structure
REQ-022 Entry state enum, entry struct (addr, data, strb) and FSM enum SHALL live in store_unit_pkg.
REQ-023 Per-lane youngest-match priority selector SHALL be sub-module sb_forward_select, parameterised on DEPTH.

Verification
REQ-024 Push 0x100/0xDEADBEEF/strb 1111, commit, mem_done_i 2 cycles after mem_req_o -> mem_req_o rises 2 cycles after commit, mem_addr_o=0x100, empty_o=1 after done.
REQ-025 Push 0x200 data 0x11223344 strb 0011 then 0x200 data 0xAABBCCDD strb 0110, fwd_addr_i=0x202 -> fwd_data_o=0x00BBCC44, fwd_strb_o=0111.
REQ-026 DEPTH=8: push 8 without commit -> full_o=1, push_ready_o=0, 9th push dropped; flush -> count_o=0, empty_o=1, no mem_req_o.
REQ-027 Push 4, commit 2, flush with commit_i high -> 3 entries drain in order, 4th discarded, tail equals commit pointer.
REQ-028 Pointer wrap: 20 push/commit/drain cycles with DEPTH=4 -> all 20 writes appear on mem port in order, no loss.
REQ-029 rst_i pulsed while mem_req_o=1 -> mem_req_o=0 same cycle, count_o=0, later mem_done_i ignored.

Source files
------------

// File: rtl/merging_store_buffer_pkg.sv
// ==== store_unit_pkg : shared types for the merging store buffer ==== rev 1.0 ====
`default_nettype none

package store_unit_pkg;

  // Entry payload is sized for the widest supported configuration; instances slice it down.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 128;
  localparam int MAX_NB     = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    ENT_FREE      = 2'd0,
    ENT_SPEC      = 2'd1,
    ENT_COMMITTED = 2'd2,
    ENT_INFLIGHT  = 2'd3
  } entry_state_e;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_NB-1:0]     strb;
  } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/merging_store_buffer_if.sv
// ==== merging_store_buffer_if : push / commit / drain / forward bus ==== rev 1.0 ====
`default_nettype none

interface merging_store_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              push_valid_i;
  logic              push_ready_o;
  logic [ADDR_W-1:0] push_addr_i;
  logic [DATA_W-1:0] push_data_i;
  logic [NB-1:0]     push_strb_i;
  logic              commit_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [NB-1:0]     mem_strb_o;
  logic              mem_done_i;
  logic [ADDR_W-1:0] fwd_addr_i;
  logic [DATA_W-1:0] fwd_data_o;
  logic [NB-1:0]     fwd_strb_o;
  logic              fwd_hit_o;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  flush_i, push_valid_i, push_addr_i, push_data_i, push_strb_i,
           commit_i, mem_done_i, fwd_addr_i,
    output push_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_strb_o,
           fwd_data_o, fwd_strb_o, fwd_hit_o, full_o, empty_o, count_o
  );

  modport master (
    output flush_i, push_valid_i, push_addr_i, push_data_i, push_strb_i,
           commit_i, mem_done_i, fwd_addr_i,
    input  push_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_strb_o,
           fwd_data_o, fwd_strb_o, fwd_hit_o, full_o, empty_o, count_o
  );

endinterface

`default_nettype wire

// File: rtl/merging_store_buffer_sb_forward_select.sv
// ==== sb_forward_select : per-lane youngest-matching-entry picker ==== rev 1.0 ====
`default_nettype none

module sb_forward_select #(
  parameter int DEPTH = 8,
  parameter int NB    = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]           tail_ptr,
  input  logic [NB-1:0][DEPTH-1:0]   lane_match,
  output logic [NB-1:0]              lane_hit,
  output logic [NB-1:0][PTR_W-1:0]   lane_sel
);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches override earlier ones.
    always_comb begin
      lane_hit[b] = 1'b0;
      lane_sel[b] = '0;
      idx         = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        idx = tail_ptr - PTR_W'(k);
        if (lane_match[b][idx]) begin
          lane_hit[b] = 1'b1;
          lane_sel[b] = idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/merging_store_buffer.sv
// ==== merging_store_buffer : speculative store FIFO with commit, drain and load forwarding ==== rev 1.0 ====
`default_nettype none

module merging_store_buffer
  import store_unit_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  merging_store_buffer_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_state_e             state      [DEPTH];
  entry_state_e             state_next [DEPTH];
  sb_entry_t                entries    [DEPTH];
  logic [PTR_W-1:0]         head_ptr, cmt_ptr, tail_ptr;
  logic [CNT_W-1:0]         count, spec_cnt, flush_drop;
  drain_state_e             drain, drain_next;
  logic                     full, push_fire, commit_fire, drain_start, drain_done;
  logic [NB-1:0][DEPTH-1:0] lane_match;
  logic [NB-1:0]            lane_hit;
  logic [NB-1:0][PTR_W-1:0] lane_sel;
  logic [DATA_W-1:0]        fwd_data;

  assign full              = (count == CNT_W'(DEPTH));
  assign bus.full_o        = full;
  assign bus.empty_o       = (count == '0);
  assign bus.count_o       = count;
  assign bus.push_ready_o  = !full && !bus.flush_i;
  assign push_fire         = bus.push_valid_i && bus.push_ready_o;
  assign commit_fire       = bus.commit_i && (state[cmt_ptr] == ENT_SPEC);
  assign drain_start       = (drain == DRAIN_IDLE) && (state[head_ptr] == ENT_COMMITTED);
  assign drain_done        = (drain == DRAIN_REQ) && bus.mem_done_i;

  always_comb begin
    drain_next = drain;
    case (drain)
      DRAIN_IDLE: if (state[head_ptr] == ENT_COMMITTED) drain_next = DRAIN_REQ;
      DRAIN_REQ:  if (bus.mem_done_i) drain_next = DRAIN_IDLE;
      default:    drain_next = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    spec_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      if (state[i] == ENT_SPEC) spec_cnt = spec_cnt + CNT_W'(1);
  end

  // The entry committed in the flush cycle survives, so it is not part of the discard.
  assign flush_drop = bus.flush_i ? (spec_cnt - CNT_W'(commit_fire)) : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_next[i] = state[i];
      if (bus.flush_i && state[i] == ENT_SPEC)           state_next[i] = ENT_FREE;
      if (commit_fire && PTR_W'(i) == cmt_ptr)           state_next[i] = ENT_COMMITTED;
      if (push_fire   && PTR_W'(i) == tail_ptr)          state_next[i] = ENT_SPEC;
      if (drain_start && PTR_W'(i) == head_ptr)          state_next[i] = ENT_INFLIGHT;
      if (drain_done  && PTR_W'(i) == head_ptr)          state_next[i] = ENT_FREE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) state[i] <= ENT_FREE;
      head_ptr <= '0;
      cmt_ptr  <= '0;
      tail_ptr <= '0;
      count    <= '0;
      drain    <= DRAIN_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) state[i] <= state_next[i];
      drain <= drain_next;
      if (drain_done)  head_ptr <= head_ptr + PTR_W'(1);
      if (commit_fire) cmt_ptr  <= cmt_ptr + PTR_W'(1);
      if (bus.flush_i)    tail_ptr <= commit_fire ? cmt_ptr + PTR_W'(1) : cmt_ptr;
      else if (push_fire) tail_ptr <= tail_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_fire) - CNT_W'(drain_done) - flush_drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire)
      entries[tail_ptr] <= '{addr: MAX_ADDR_W'(bus.push_addr_i),
                             data: MAX_DATA_W'(bus.push_data_i),
                             strb: MAX_NB'(bus.push_strb_i)};
  end

  assign bus.mem_req_o  = (drain == DRAIN_REQ);
  assign bus.mem_addr_o = entries[head_ptr].addr[ADDR_W-1:0];
  assign bus.mem_data_o = entries[head_ptr].data[DATA_W-1:0];
  assign bus.mem_strb_o = entries[head_ptr].strb[NB-1:0];

  always_comb begin
    lane_match = '0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < DEPTH; i++)
        lane_match[b][i] = (state[i] != ENT_FREE) && entries[i].strb[b] &&
                           (entries[i].addr[ADDR_W-1:2] == bus.fwd_addr_i[ADDR_W-1:2]);
  end

  sb_forward_select #(.DEPTH(DEPTH), .NB(NB)) u_fwd_sel (
    .tail_ptr   (tail_ptr),
    .lane_match (lane_match),
    .lane_hit   (lane_hit),
    .lane_sel   (lane_sel)
  );

  always_comb begin
    fwd_data = '0;
    for (int b = 0; b < NB; b++)
      if (lane_hit[b]) fwd_data[8*b +: 8] = entries[lane_sel[b]].data[8*b +: 8];
  end

  assign bus.fwd_data_o = fwd_data;
  assign bus.fwd_strb_o = lane_hit;
  assign bus.fwd_hit_o  = |lane_hit;

  commit_needs_spec: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.commit_i |-> (state[cmt_ptr] == ENT_SPEC));

endmodule

`default_nettype wire
